// File: rtl/lwb_pkg.sv
// Shared types and helpers for the multi-row line window buffer.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
//
// Contents:
//   LWB_FIFO_DEPTH    - depth of the column output queue
//   lwb_col_t         - queued column record {data, x, eol}, sized for the
//                       largest supported configuration; users zero-extend
//                       into it and slice back out
//   lwb_age_bank()    - maps a row age to the bank that holds that row
package lwb_pkg;

  localparam int LWB_FIFO_DEPTH = 2;

  // Upper bounds on ROWS*DW and on the column address width.
  localparam int LWB_MAX_DATA_W = 512;
  localparam int LWB_MAX_ADDRW  = 16;

  typedef struct packed {
    logic [LWB_MAX_DATA_W-1:0] data;
    logic [LWB_MAX_ADDRW-1:0]  x;
    logic                      eol;
  } lwb_col_t;

  // The bank currently being written holds the oldest row, and each bank
  // before it (circularly) holds a row one line younger. So age k lives
  // (nbanks - k) banks ahead of the write bank.
  function automatic int lwb_age_bank(input int wr_bank, input int age, input int nbanks);
    return (wr_bank + nbanks - age) % nbanks;
  endfunction

endpackage

// File: rtl/lwb_bank.sv
// One line of pixel storage: simple dual-port SRAM, registered read, read-before-write.
// Latency: read data valid one cycle after rd_en.
// Backpressure: none; accepts a read and a write every cycle.
//
// Ports:
//   clk                  - clock
//   rd_en, rd_addr       - read request; rd_data updates on the next edge
//   rd_data              - registered read data (old contents on address collision)
//   wr_en, wr_addr, wr_data - write port
// Contents are intentionally not reset.
module lwb_bank #(
  parameter int DW    = 8,
  parameter int DEPTH = 640,
  parameter int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [ADDRW-1:0] rd_addr,
  output logic [DW-1:0]    rd_data,
  input  logic             wr_en,
  input  logic [ADDRW-1:0] wr_addr,
  input  logic [DW-1:0]    wr_data
);

  logic [DW-1:0] mem [DEPTH];

  // Both accesses sample mem before the edge, so a same-address read
  // returns the row being overwritten.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/line_window_buf.sv
// Streaming line buffer: emits one ROWS-tall pixel column per accepted pixel.
// Latency: 2 cycles from input acceptance to col_valid_o.
// Backpressure: at most 2 columns buffered (queue + in-flight read); pix_ready_o drops when full with no pop.
//
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   pix_valid_i/ready_o    - input pixel handshake
//   pix_sof_i              - start of frame, restarts column and line count
//   pix_data_i             - input pixel
//   col_valid_o/ready_i    - output column handshake
//   col_data_o             - slice 0 is the current row, slice k is k lines earlier
//   col_x_o, col_eol_o     - column index and end-of-line flag of the emitted column
// Build option: LWB_BORDER_REPLICATE_EN emits from line 0 of each frame, replacing
// rows older than the frame start with row 0 (top border replication).
module line_window_buf
  import lwb_pkg::*;
#(
  parameter int DW     = 8,
  parameter int LINE_W = 640,
  parameter int ROWS   = 3,
  parameter int ADDRW  = $clog2(LINE_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_valid_i,
  output logic                 pix_ready_o,
  input  logic                 pix_sof_i,
  input  logic [DW-1:0]        pix_data_i,
  output logic                 col_valid_o,
  input  logic                 col_ready_i,
  output logic [ROWS*DW-1:0]   col_data_o,
  output logic [ADDRW-1:0]     col_x_o,
  output logic                 col_eol_o
);

  localparam int NBANK = ROWS - 1;
  localparam int BIW   = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int LCW   = $clog2(ROWS);
  localparam int CW    = ROWS * DW;
  localparam int PTRW  = (LWB_FIFO_DEPTH > 1) ? $clog2(LWB_FIFO_DEPTH) : 1;
  localparam int CNTW  = $clog2(LWB_FIFO_DEPTH + 1);
  localparam int OCCW  = CNTW + 1;

  // ---------------------------------------------------------------------------
  // Raster position tracking
  // ---------------------------------------------------------------------------
  logic [ADDRW-1:0] x_q;
  logic [LCW-1:0]   line_cnt_q;
  logic [BIW-1:0]   wr_bank_q;

  logic             fire;
  logic [ADDRW-1:0] cur_x;
  logic [LCW-1:0]   cur_line;
  logic             cur_eol;
  logic             cur_emit;

  assign fire     = pix_valid_i && pix_ready_o;
  // SOF applies to the pixel that carries it, not the next one.
  assign cur_x    = pix_sof_i ? '0 : x_q;
  assign cur_line = pix_sof_i ? '0 : line_cnt_q;
  assign cur_eol  = (cur_x == ADDRW'(LINE_W - 1));

`ifdef LWB_BORDER_REPLICATE_EN
  assign cur_emit = 1'b1;
`else
  // Only once ROWS-1 full lines of this frame are stored is the column real.
  assign cur_emit = (cur_line == LCW'(ROWS - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= '0;
      line_cnt_q <= '0;
      wr_bank_q  <= '0;
    end else if (fire) begin
      if (cur_eol) begin
        x_q        <= '0;
        wr_bank_q  <= (wr_bank_q == BIW'(NBANK - 1)) ? '0 : wr_bank_q + 1'b1;
        line_cnt_q <= (cur_line == LCW'(ROWS - 1)) ? cur_line : cur_line + 1'b1;
      end else begin
        x_q        <= cur_x + 1'b1;
        line_cnt_q <= cur_line;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line storage: every bank is read at x, the write bank is overwritten at x
  // ---------------------------------------------------------------------------
  logic [DW-1:0] bank_rd [NBANK];

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    lwb_bank #(
      .DW    (DW),
      .DEPTH (LINE_W),
      .ADDRW (ADDRW)
    ) u_bank (
      .clk     (clk),
      .rd_en   (fire),
      .rd_addr (cur_x),
      .rd_data (bank_rd[b]),
      .wr_en   (fire && (wr_bank_q == BIW'(b))),
      .wr_addr (cur_x),
      .wr_data (pix_data_i)
    );
  end

  // ---------------------------------------------------------------------------
  // s1: side information travelling with the bank read; never stalls because
  // pix_ready_o already reserved a queue slot for it.
  // ---------------------------------------------------------------------------
  logic             s1_valid;
  logic             s1_emit;
  logic             s1_eol;
  logic [DW-1:0]    s1_pix;
  logic [ADDRW-1:0] s1_x;
  logic [BIW-1:0]   s1_bank;
`ifdef LWB_BORDER_REPLICATE_EN
  logic [LCW-1:0]   s1_line;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= fire;
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      s1_emit <= cur_emit;
      s1_eol  <= cur_eol;
      s1_pix  <= pix_data_i;
      s1_x    <= cur_x;
      s1_bank <= wr_bank_q;
`ifdef LWB_BORDER_REPLICATE_EN
      s1_line <= cur_line;
`endif
    end
  end

  // Reorder bank outputs by row age.
  logic [CW-1:0] col_vec;

  always_comb begin
`ifdef LWB_BORDER_REPLICATE_EN
    int src;
    src = 0;
`endif
    col_vec          = '0;
    col_vec[DW-1:0]  = s1_pix;
    for (int k = 1; k < ROWS; k++) begin
`ifdef LWB_BORDER_REPLICATE_EN
      // Rows before the frame start are stale; clamp to row 0 of the frame.
      // When the current pixel is itself on row 0, that row is s1_pix.
      src = (k > int'(s1_line)) ? int'(s1_line) : k;
      if (src == 0) begin
        col_vec[k*DW +: DW] = s1_pix;
      end else begin
        col_vec[k*DW +: DW] = bank_rd[BIW'(lwb_age_bank(int'(s1_bank), src, NBANK))];
      end
`else
      col_vec[k*DW +: DW] = bank_rd[BIW'(lwb_age_bank(int'(s1_bank), k, NBANK))];
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Output queue
  // ---------------------------------------------------------------------------
  lwb_col_t        fifo_mem [LWB_FIFO_DEPTH];
  lwb_col_t        push_col;
  lwb_col_t        head;
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW-1:0] wr_ptr;
  logic [CNTW-1:0] fifo_cnt;
  logic [OCCW-1:0] occ;
  logic            push;
  logic            pop;

  assign push = s1_valid && s1_emit;
  assign pop  = col_valid_o && col_ready_i;

  always_comb begin
    push_col      = '0;
    push_col.data = LWB_MAX_DATA_W'(col_vec);
    push_col.x    = LWB_MAX_ADDRW'(s1_x);
    push_col.eol  = s1_eol;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTRW'(LWB_FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTRW'(LWB_FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_col;
    end
  end

  // s1 counts as occupied even when it will not push: keeps the slot
  // reservation independent of the emit decision.
  assign occ         = OCCW'(fifo_cnt) + OCCW'(s1_valid) - OCCW'(pop);
  assign pix_ready_o = (occ < OCCW'(LWB_FIFO_DEPTH));

  assign head        = fifo_mem[rd_ptr];
  assign col_valid_o = (fifo_cnt != '0);
  // Gate with valid so the uninitialised queue never shows on the outputs.
  assign col_data_o  = col_valid_o ? head.data[CW-1:0]  : '0;
  assign col_x_o     = col_valid_o ? head.x[ADDRW-1:0]  : '0;
  assign col_eol_o   = col_valid_o && head.eol;

  // Spare bits of the max-width record are zero by construction.
  logic unused_head_bits;
  assign unused_head_bits = ^head;

endmodule

// File: tb/tb_line_window_buf.sv
module tb_line_window_buf;

  localparam int DW     = 8;
  localparam int LINE_W = 4;
  localparam int ROWS   = 3;
  localparam int ADDRW  = $clog2(LINE_W);
`ifdef LWB_BORDER_REPLICATE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                pix_valid_i;
  logic                pix_ready_o;
  logic                pix_sof_i;
  logic [DW-1:0]       pix_data_i;
  logic                col_valid_o;
  logic                col_ready_i;
  logic [ROWS*DW-1:0]  col_data_o;
  logic [ADDRW-1:0]    col_x_o;
  logic                col_eol_o;

  always #5 clk = ~clk;

  line_window_buf #(
    .DW(DW), .LINE_W(LINE_W), .ROWS(ROWS), .ADDRW(ADDRW)
  ) dut (
    .clk(clk), .rst(rst),
    .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .pix_sof_i(pix_sof_i), .pix_data_i(pix_data_i),
    .col_valid_o(col_valid_o), .col_ready_i(col_ready_i),
    .col_data_o(col_data_o), .col_x_o(col_x_o), .col_eol_o(col_eol_o)
  );

  // Consumer ready: manual level, or random when rnd_mode is set.
  bit   rnd_mode = 1'b0;
  logic man_rdy;
  logic rnd_rdy = 1'b1;
  assign col_ready_i = rnd_mode ? rnd_rdy : man_rdy;

  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  int n_cmp = 0;
  int n_err = 0;
  int n_push = 0;
  int n_pop = 0;
  int cyc = 0;
  bit lat_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: frame image kept per line, ring of ROWS lines.
  // Pixel (line L, x) yields a column iff L >= ROWS-1 (or always with border
  // replication); row age k is the pixel at line L-k, clamped to line 0.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [ROWS*DW-1:0] data;
    int                 x;
    bit                 eol;
    int                 acc_cyc;
    bit                 chk_lat;
  } exp_t;

  exp_t          exp_q[$];
  int            m_line = 0;
  int            m_x = 0;
  logic [DW-1:0] img [ROWS][LINE_W];

  always @(negedge clk) begin
    if (rst) begin
      m_line = 0;
      m_x    = 0;
      exp_q.delete();
    end else if (pix_valid_i && pix_ready_o) begin
      exp_t e;
      int   src;
      if (pix_sof_i) begin
        m_line = 0;
        m_x    = 0;
      end
      img[m_line % ROWS][m_x] = pix_data_i;
      if (REPL || m_line >= ROWS - 1) begin
        e.data = '0;
        for (int k = 0; k < ROWS; k++) begin
          src = m_line - k;
          if (src < 0) src = 0;
          e.data[k*DW +: DW] = img[src % ROWS][m_x];
        end
        e.x       = m_x;
        e.eol     = (m_x == LINE_W - 1);
        e.acc_cyc = cyc;
        e.chk_lat = lat_mode;
        exp_q.push_back(e);
        n_push++;
      end
      m_x++;
      if (m_x == LINE_W) begin
        m_x = 0;
        m_line++;
      end
    end
  end

  // Monitor: compares each column as it is handed over.
  always @(negedge clk) begin
    if (!rst && col_valid_o && col_ready_i) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_col: got data=%h x=%0d, required no column", col_data_o, col_x_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("col_data", 64'(col_data_o), 64'(e.data));
        check("col_x", 64'(col_x_o), 64'(e.x));
        check("col_eol", 64'(col_eol_o), 64'(e.eol));
        if (e.chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'd2);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send(input logic [DW-1:0] d, input bit sof);
    bit acc;
    acc = 1'b0;
    pix_valid_i = 1'b1;
    pix_data_i  = d;
    pix_sof_i   = sof;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = pix_ready_o;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got no acceptance, required acceptance within 200 cycles");
    end
    pix_valid_i = 1'b0;
    pix_sof_i   = 1'b0;
  endtask

  task automatic send_lines(input int nlines, input int base, input bit first_sof);
    for (int l = 0; l < nlines; l++)
      for (int x = 0; x < LINE_W; x++)
        send(DW'(base + 16 * l + x), first_sof && l == 0 && x == 0);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || col_valid_o) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_drain: got %0d columns pending, required 0 within 100 cycles", name, exp_q.size());
    end
  endtask

  // Holds pix_valid_i high with the consumer stalled; returns accept count.
  task automatic stall_push(input int ncyc, input logic [DW-1:0] base, output int nacc);
    bit a;
    nacc        = 0;
    man_rdy     = 1'b0;
    pix_valid_i = 1'b1;
    pix_sof_i   = 1'b0;
    pix_data_i  = base;
    repeat (ncyc) begin
      @(negedge clk);
      a = pix_ready_o;
      @(posedge clk);
      #1;
      if (a) begin
        nacc++;
        pix_data_i = pix_data_i + 8'd1;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nacc;
    rst         = 1'b1;
    pix_valid_i = 1'b0;
    pix_sof_i   = 1'b0;
    pix_data_i  = '0;
    man_rdy     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pix_ready", 64'(pix_ready_o), 64'd1);
    check("reset_col_valid", 64'(col_valid_o), 64'd0);
    check("reset_col_data", 64'(col_data_o), 64'd0);
    check("reset_col_x", 64'(col_x_o), 64'd0);
    check("reset_col_eol", 64'(col_eol_o), 64'd0);
    rst = 1'b0;

    // Warm-up and rotation: pixel = 16*line + x, consumer always ready.
    man_rdy  = 1'b1;
    lat_mode = 1'b1;
    send_lines(4, 0, 1'b1);
    drain("warmup");
    lat_mode = 1'b0;

    // Backpressure: only two columns may be taken while the consumer stalls.
    stall_push(8, 8'h40, nacc);
    pix_valid_i = 1'b0;
    check("bp_accept_count", 64'(nacc), 64'd2);
    check("bp_pix_ready_low", 64'(pix_ready_o), 64'd0);
    check("bp_col_valid", 64'(col_valid_o), 64'd1);
    man_rdy = 1'b1;
    drain("backpressure");

    // SOF mid-line (x=2 after the two backpressure pixels).
    send_lines(3, 8'h80, 1'b1);
    drain("sof");

    // Reset mid-frame with the queue full.
    stall_push(4, 8'h60, nacc);
    check("rst_pre_col_valid", 64'(col_valid_o), 64'd1);
    rst         = 1'b1;
    pix_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_col_valid", 64'(col_valid_o), 64'd0);
    check("rst_mid_pix_ready", 64'(pix_ready_o), 64'd1);
    check("rst_mid_col_data", 64'(col_data_o), 64'd0);
    man_rdy = 1'b1;
    send_lines(3, 8'hC0, 1'b0);
    drain("rst_warmup");

    // Random traffic with random consumer stalls and occasional SOF.
    rnd_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(DW'($urandom_range(0, 255)), $urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_mode = 1'b0;
    man_rdy  = 1'b1;
    drain("random");

    check("end_queue_empty", 64'(exp_q.size()), 64'd0);
    check("end_columns_seen", 64'(n_pop > 0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
